// File: rtl/arm_pipe_pkg.sv
// Shared decode definitions for the ARM-style pipeline: shifter operand type
// codes, instruction field positions, and the decoded control record layout.
package arm_pipe_pkg;

   typedef enum logic [2:0] {
      SH_DP_IMM_SHIFT = 3'b000,
      SH_DP_IMM       = 3'b001,
      SH_LS_IMM       = 3'b010,
      SH_LS_REG       = 3'b011,
      SH_ILLEGAL      = 3'b111
   } sh_type_t;

   // Occupancy encoding is {main_valid, skid_valid}; 2'b01 is never produced.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL1 = 2'b10,
      FULL2 = 2'b11
   } occ_state_t;

   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned COND_LSB  = 28;
   localparam int unsigned CLASS_LSB = 25;
   localparam int unsigned OPC_LSB   = 21;
   localparam int unsigned S_BIT     = 20;
   localparam int unsigned RD_LSB    = 12;
   localparam int unsigned SHIFT_W   = 12;
   localparam int unsigned REGSH_BIT = 4;

   typedef struct packed {
      logic [SHIFT_W-1:0] shift;
      logic [2:0]         sh_type;
      logic [3:0]         opcode;
      logic               s;
      logic [3:0]         rd;
      logic [3:0]         cond;
      logic               illegal;
   } id_ctrl_t;

   localparam int unsigned CTRL_W = $bits(id_ctrl_t);

endpackage

// File: rtl/shift_type_decode.sv
// Combinational shifter operand classifier: instr -> {type, illegal}.
// Shared between the ID/EX operand stage and the hazard unit.
module shift_type_decode
   import arm_pipe_pkg::*;
(
   input  logic [31:0] instr,
   output logic [2:0]  sh_type,
   output logic        illegal
);

   logic [2:0] op_class;
   logic       reg_shift;
   logic       unused_instr_bits;

   assign op_class  = instr[CLASS_LSB +: 3];
   assign reg_shift = instr[REGSH_BIT];
   assign unused_instr_bits = ^{instr[31:28], instr[24:5], instr[3:0]};

   always_comb begin
      sh_type = SH_ILLEGAL;
      illegal = 1'b1;
      case (op_class)
         3'b000: if (!reg_shift) begin
            sh_type = SH_DP_IMM_SHIFT;
            illegal = 1'b0;
         end
         3'b001: begin
            sh_type = SH_DP_IMM;
            illegal = 1'b0;
         end
         3'b010: begin
            sh_type = SH_LS_IMM;
            illegal = 1'b0;
         end
         3'b011: if (!reg_shift) begin
            sh_type = SH_LS_REG;
            illegal = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// Decode-to-execute operand stage with a two-entry skid buffer and flush.
// Optional saturating stall counter enabled by ID_EX_STALL_CNT_EN.
module id_ex_operand_stage
   import arm_pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [DATA_W-1:0] in_rn,
   input  logic [DATA_W-1:0] in_rm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_rn,
   output logic [DATA_W-1:0] out_rm,
   output logic [11:0]       out_shift,
   output logic [2:0]        out_type,
   output logic [3:0]        out_opcode,
   output logic              out_s,
   output logic [REG_W-1:0]  out_rd,
   output logic [3:0]        out_cond,
   output logic              out_illegal
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   typedef struct packed {
      logic [DATA_W-1:0] rn;
      logic [DATA_W-1:0] rm;
      id_ctrl_t          ctrl;
   } entry_t;

   occ_state_t state_q, state_d;
   entry_t     main_q, skid_q, new_e;
   logic       load_main_new, load_main_skid, load_skid;
   logic       accept, consume;
   logic [2:0] dec_type;
   logic       dec_illegal;
   logic       unused_rn_field;

   shift_type_decode u_dec (
      .instr   (in_instr),
      .sh_type (dec_type),
      .illegal (dec_illegal)
   );

   assign unused_rn_field = ^in_instr[19:16];

   always_comb begin
      new_e              = '0;
      new_e.rn           = in_rn;
      new_e.rm           = in_rm;
      new_e.ctrl.shift   = in_instr[SHIFT_W-1:0];
      new_e.ctrl.sh_type = dec_type;
      new_e.ctrl.opcode  = in_instr[OPC_LSB +: 4];
      new_e.ctrl.s       = in_instr[S_BIT];
      new_e.ctrl.rd      = in_instr[RD_LSB +: 4];
      new_e.ctrl.cond    = in_instr[COND_LSB +: 4];
      new_e.ctrl.illegal = dec_illegal;
   end

   assign in_ready  = (state_q != FULL2);
   assign out_valid = (state_q != EMPTY);
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;

   always_comb begin
      state_d        = state_q;
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (accept) begin
               load_main_new = 1'b1;
               state_d       = FULL1;
            end
            FULL1: begin
               if (accept && consume) begin
                  load_main_new = 1'b1;
               end else if (accept) begin
                  load_skid = 1'b1;
                  state_d   = FULL2;
               end else if (consume) begin
                  state_d = EMPTY;
               end
            end
            FULL2: if (consume) begin
               load_main_skid = 1'b1;
               state_d        = FULL1;
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_new) begin
            main_q <= new_e;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= new_e;
         end
      end
   end

   assign out_rn      = main_q.rn;
   assign out_rm      = main_q.rm;
   assign out_shift   = main_q.ctrl.shift;
   assign out_type    = main_q.ctrl.sh_type;
   assign out_opcode  = main_q.ctrl.opcode;
   assign out_s       = main_q.ctrl.s;
   assign out_rd      = REG_W'(main_q.ctrl.rd);
   assign out_cond    = main_q.ctrl.cond;
   assign out_illegal = main_q.ctrl.illegal;

`ifdef ID_EX_STALL_CNT_EN
   logic [15:0] stall_q;

   // Only reset clears the count; flush leaves it running.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != '1)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline stage that sits directly upstream of the shifter and ALU.
- Captures the decoded instruction fields and register-file operands (Rn, Rm).
- Classifies the shifter operand type and presents Rm_in/shift_in/type_in-ready fields to execute.
- Two-entry skid buffer with valid/ready handshakes on both sides; flush for branch and exception recovery.

Parameters:
- DATA_W, 32: operand width.
- REG_W, 4: register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- flush  in  1  discard all held and incoming entries.
- in_valid  in  1  decode has an entry.
- in_ready  out  1  stage can accept; equals !skid_valid, registered-state only, no in_valid path.
- in_instr  in  32  raw instruction word.
- in_rn  in  DATA_W  Rn value read in decode.
- in_rm  in  DATA_W  Rm value read in decode.
- out_valid  out  1  entry presented to execute.
- out_ready  in  1  execute consumes this cycle.
- out_rn  out  DATA_W  Rn operand.
- out_rm  out  DATA_W  shifter Rm_in.
- out_shift  out  12  instr[11:0], shifter shift_in.
- out_type  out  3  shifter type_in.
- out_opcode  out  4  instr[24:21].
- out_s  out  1  instr[20].
- out_rd  out  REG_W  instr[15:12].
- out_cond  out  4  instr[31:28].
- out_illegal  out  1  unsupported encoding flag.

Behaviour:
- Reset (synchronous, active-high):
  - main_valid=0, skid_valid=0; all out_* data fields=0; out_type=3'b000; out_illegal=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Accept when in_valid&&in_ready. Consume when out_valid&&out_ready. out_valid=main_valid.
- Type decode, applied on capture:
  - instr[27:25]=000 && instr[4]=0 -> 000 (DP immediate shift).
  - 001 -> 001 (DP immediate).
  - 010 -> 010 (LS immediate offset).
  - 011 && instr[4]=0 -> 011 (LS register offset).
  - Anything else -> 3'b111 with illegal=1 (register-shifted register, media, branch, coprocessor). Such entries still flow; execute treats them as NOP.
- State machine on {main_valid, skid_valid}, registered each edge:
  - EMPTY (00): accept -> main, goes FULL1.
  - FULL1 (10):
    - accept && consume -> main<=new, stays FULL1.
    - accept && !consume -> new goes to skid, goes FULL2.
    - consume only -> EMPTY.
  - FULL2 (11): in_ready=0.
    - consume -> main<=skid, skid cleared, goes FULL1.
    - Otherwise hold.
  - State 01 is unreachable; verification asserts it never occurs.
- Latency: captured entry visible on out_* the edge after acceptance (1 cycle). Throughput 1 entry/cycle when out_ready is held high. FIFO order always preserved.
- Stability: while out_valid && !out_ready, every out_* field holds its value.
- flush:
  - Next edge: main_valid=0, skid_valid=0.
  - An entry offered in the flush cycle is dropped even if the handshake completes.
  - A consume in the same cycle counts as delivered.
  - Data fields need not clear.
- reset && flush together: reset wins (identical visible result).
- Reset mid-transfer: entries are discarded, with no partial output.

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- With it:
  - Adds output stall_cnt [15:0].
  - Increments each cycle out_valid && !out_ready; saturates at 16'hFFFF.
  - Cleared only by reset; flush does not clear it.
- Without it: no port, no counter logic.

Decomposition:
- Package arm_pipe_pkg holds:
  - Shifter type codes: SH_DP_IMM_SHIFT=3'b000, SH_DP_IMM=3'b001, SH_LS_IMM=3'b010, SH_LS_REG=3'b011, SH_ILLEGAL=3'b111.
  - Instruction field bit positions.
  - Entry record layout (width constant).
- Sub-module shift_type_decode: combinational, instr -> {type, illegal}. The same code is reused by the hazard unit.

Test Plan:
- in_instr=32'hE1A01102 (MOV r1,r2,LSL#2), in_rm=32'h00000005, out_ready=1 -> next cycle out_type=000, out_shift=12'h102, out_rm=5, out_rd=1, out_illegal=0.
- Back-to-back instructions 32'hE3A00FFF, 32'hE5910004, 32'hE7910002, with out_ready=1 -> one per cycle in order:
  - types 001, 010, 011.
  - out_shift = 12'hFFF, 12'h004, 12'h002.
- Hold out_ready=0 and offer three entries A, B, C:
  - A and B accepted; in_ready=0 after B; C held off.
  - out_* stays A.
  - Raise out_ready -> A, B, C delivered in order, one per cycle.
- FULL2 state, assert flush while in_valid=1 -> next cycle out_valid=0 and in_ready=1; the flushed-cycle entry never appears.
- in_instr=32'hE0810312 (register-shifted register) -> out_type=111, out_illegal=1, entry still delivered.
- With ID_EX_STALL_CNT_EN:
  - 5 stalled cycles -> stall_cnt=5.
  - Force the counter near 16'hFFFF and stall further -> it stays at 16'hFFFF.
  - reset -> 0.
